// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: opcodes, immediate format codes and the decoded entry shared by the decode slice
package rv_decode_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    EXT_I      = 3'b000,
    EXT_S      = 3'b001,
    EXT_B      = 3'b010,
    EXT_U      = 3'b011,
    EXT_J      = 3'b100,
    EXT_UIMM   = 3'b101,
    EXT_BYPASS = 3'b110,
    EXT_NONE   = 3'b111
  } ext_ctrl_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    ext_ctrl_e   ext_control;
    logic        has_imm;
    logic        illegal;
  } decode_entry_t;
endpackage

// File: rtl/extender.sv
// extender: builds a 32-bit immediate from instr[31:7] according to a 3-bit format code
module extender (
  input  logic [24:0] src,
  input  logic [2:0]  ext_control,
  output logic [31:0] imm
);
  // src[k] is instr[k+7]; unknown codes yield zero so the output never carries X
  always_comb begin
    case (ext_control)
      3'b000:  imm = {{20{src[24]}}, src[24:13]};
      3'b001:  imm = {{20{src[24]}}, src[24:18], src[4:0]};
      3'b010:  imm = {{19{src[24]}}, src[24], src[0], src[23:18], src[4:1], 1'b0};
      3'b011:  imm = {src[24:5], 12'b0};
      3'b100:  imm = {{11{src[24]}}, src[24], src[12:5], src[13], src[23:14], 1'b0};
      3'b101:  imm = {27'b0, src[17:13]};
      3'b110:  imm = {src, 7'b0};
      default: imm = 32'b0;
    endcase
  end
endmodule

// File: rtl/imm_decode_stage_skid.sv
// skid_buffer: two-entry output/skid register pair with registered ready and synchronous flush
module skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  logic skid_valid;
  T     skid_data;
  logic accept;
  logic load_out;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign load_out = !out_valid || out_ready;

  // output register refills from skid first, else from the input; stalled accepts park in skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      out_valid  <= skid_valid || accept;
      skid_valid <= 1'b0;
      if (skid_valid) out_data <= skid_data;
      else if (accept) out_data <= in_data;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: classifies RV32I words, extends their immediate and registers the result
module imm_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_ext_control,
  output logic            out_has_imm,
  output logic            out_illegal
);
  ext_ctrl_e     ext;
  logic          has_imm;
  logic          illegal;
  logic [31:0]   ext_imm;
  decode_entry_t in_e;
  decode_entry_t out_e;
  logic [6:0]    opc;
  logic [2:0]    f3;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];

  // opcode/funct3 to immediate format; OP and unknown opcodes carry no immediate
  always_comb begin
    ext     = EXT_I;
    has_imm = 1'b1;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_FENCE, OPC_JALR: ext = EXT_I;
      OPC_OPIMM:           ext = (f3 == 3'b001 || f3 == 3'b101) ? EXT_UIMM : EXT_I;
      OPC_STORE:           ext = EXT_S;
      OPC_BRANCH:          ext = EXT_B;
      OPC_LUI, OPC_AUIPC:  ext = EXT_U;
      OPC_JAL:             ext = EXT_J;
      OPC_SYSTEM:          ext = EXT_BYPASS;
      OPC_OP:              has_imm = 1'b0;
      default: begin
        ext     = EXT_NONE;
        has_imm = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

  extender u_ext (
    .src         (in_instr[31:7]),
    .ext_control (ext),
    .imm         (ext_imm)
  );

  assign in_e = '{pc: in_pc, instr: in_instr, imm: has_imm ? ext_imm : 32'b0,
                  ext_control: ext, has_imm: has_imm, illegal: illegal};

  skid_buffer #(.T(decode_entry_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_e)
  );

  assign out_pc          = out_e.pc;
  assign out_instr       = out_e.instr;
  assign out_imm         = out_e.imm;
  assign out_ext_control = out_e.ext_control;
  assign out_has_imm     = out_e.has_imm;
  assign out_illegal     = out_e.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed checks of decode, handshake, skid, flush and async reset
module tb_imm_decode_stage;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_instr = 0;
  logic [31:0] in_pc = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [2:0]  out_ext_control;
  logic        out_has_imm;
  logic        out_illegal;
  int passed = 0;
  int total = 0;

  imm_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_imm(out_imm), .out_ext_control(out_ext_control), .out_has_imm(out_has_imm),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({out_valid, in_ready, out_pc, out_instr, out_imm, out_ext_control, out_has_imm, out_illegal} !== {1'b0, 1'b1, 96'b0, 3'b000, 2'b00})
      $display("FAIL reset: valid=%b ready=%b pc=%h instr=%h imm=%h ext=%b has=%b ill=%b, required 0/1 and zeros",
               out_valid, in_ready, out_pc, out_instr, out_imm, out_ext_control, out_has_imm, out_illegal);
    else passed++;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_addi();
    out_ready = 1; in_valid = 1; in_instr = 32'hFFF00093; in_pc = 32'h100;
    step();
    in_valid = 0;
    total++;
    if ({out_valid, out_imm, out_ext_control, out_has_imm, out_illegal, out_pc, out_instr} !== {1'b1, 32'hFFFFFFFF, 3'b000, 1'b1, 1'b0, 32'h100, 32'hFFF00093})
      $display("FAIL addi: valid=%b imm=%h ext=%b has=%b ill=%b pc=%h instr=%h, required 1 ffffffff 000 1 0 00000100 fff00093",
               out_valid, out_imm, out_ext_control, out_has_imm, out_illegal, out_pc, out_instr);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL addi_drain: out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5] = '{32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'h800000EF, 32'h01F09093};
    logic [31:0] imm [5] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'hFFF00000, 32'h0000001F};
    logic [2:0]  ext [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_instr = ins[i]; in_pc = 32'h200 + 32'(4 * i);
      step();
      total++;
      if ({out_valid, in_ready, out_imm, out_ext_control, out_has_imm, out_pc} !== {1'b1, 1'b1, imm[i], ext[i], 1'b1, 32'h200 + 32'(4 * i)})
        $display("FAIL b2b[%0d]: valid=%b ready=%b imm=%h ext=%b has=%b pc=%h, required 1 1 %h %b 1 %h",
                 i, out_valid, in_ready, out_imm, out_ext_control, out_has_imm, out_pc, imm[i], ext[i], 32'h200 + 32'(4 * i));
      else passed++;
    end
    in_valid = 0;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_end: out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_stall();
    out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h300;
    step();
    total++;
    if ({out_valid, in_ready, out_imm} !== {1'b1, 1'b1, 32'd1})
      $display("FAIL stall_first: valid=%b ready=%b imm=%h, required 1 1 00000001", out_valid, in_ready, out_imm);
    else passed++;
    in_instr = 32'h00200093; in_pc = 32'h304;
    step();
    total++;
    if ({out_valid, in_ready, out_imm, out_pc} !== {1'b1, 1'b0, 32'd1, 32'h300})
      $display("FAIL stall_skid: valid=%b ready=%b imm=%h pc=%h, required 1 0 00000001 00000300", out_valid, in_ready, out_imm, out_pc);
    else passed++;
    in_instr = 32'h00300093; in_pc = 32'h308;
    step();
    total++;
    if ({out_valid, in_ready, out_imm} !== {1'b1, 1'b0, 32'd1})
      $display("FAIL stall_hold: valid=%b ready=%b imm=%h, required 1 0 00000001", out_valid, in_ready, out_imm);
    else passed++;
    out_ready = 1;
    step();
    total++;
    if ({out_valid, in_ready, out_imm, out_pc} !== {1'b1, 1'b1, 32'd2, 32'h304})
      $display("FAIL stall_second: valid=%b ready=%b imm=%h pc=%h, required 1 1 00000002 00000304", out_valid, in_ready, out_imm, out_pc);
    else passed++;
    step();
    in_valid = 0;
    total++;
    if ({out_valid, in_ready, out_imm, out_pc} !== {1'b1, 1'b1, 32'd3, 32'h308})
      $display("FAIL stall_third: valid=%b ready=%b imm=%h pc=%h, required 1 1 00000003 00000308", out_valid, in_ready, out_imm, out_pc);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL stall_end: out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_no_imm();
    out_ready = 1; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h400;
    step();
    total++;
    if ({out_valid, out_has_imm, out_illegal, out_ext_control, out_imm} !== {1'b1, 1'b0, 1'b0, 3'b000, 32'h0})
      $display("FAIL op_add: valid=%b has=%b ill=%b ext=%b imm=%h, required 1 0 0 000 00000000",
               out_valid, out_has_imm, out_illegal, out_ext_control, out_imm);
    else passed++;
    in_instr = 32'h0000007F; in_pc = 32'h404;
    step();
    in_valid = 0;
    total++;
    if ({out_valid, out_has_imm, out_illegal, out_ext_control, out_imm, out_instr} !== {1'b1, 1'b0, 1'b1, 3'b111, 32'h0, 32'h0000007F})
      $display("FAIL illegal: valid=%b has=%b ill=%b ext=%b imm=%h instr=%h, required 1 0 1 111 00000000 0000007f",
               out_valid, out_has_imm, out_illegal, out_ext_control, out_imm, out_instr);
    else passed++;
    step();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h500;
    step();
    in_instr = 32'h00200093; in_pc = 32'h504;
    step();
    in_instr = 32'h00700093; in_pc = 32'h508; flush = 1;
    step();
    flush = 0; in_valid = 0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush_full: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    else passed++;
    out_ready = 1;
    in_valid = 1; in_instr = 32'h00900093; in_pc = 32'h50C; flush = 1;
    step();
    flush = 0; in_valid = 0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush_discard: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_after: out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h600;
    step();
    in_valid = 0;
    total++;
    if ({out_valid, out_imm} !== {1'b1, 32'd5})
      $display("FAIL areset_pre: valid=%b imm=%h, required 1 00000005", out_valid, out_imm);
    else passed++;
    #1 rst_n = 0;
    #1;
    total++;
    if ({out_valid, in_ready, out_imm} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL areset: valid=%b ready=%b imm=%h, required 0 1 00000000", out_valid, in_ready, out_imm);
    else passed++;
    step();
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_no_imm();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered decode slice between fetch and execute.
- Classifies each incoming RV32I instruction word and selects the immediate format, applying the same encoding the extender uses. Drives the extender with instr[31:7] and registers the 32-bit immediate with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready. A synchronous flush squashes in-flight entries on redirect.

Parameters:
- XLEN, 32, data/PC width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all buffered entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  32  PC of the entry
- out_instr  out  32  instruction word of the entry
- out_imm  out  32  extended immediate
- out_ext_control  out  3  format code used
- out_has_imm  out  1  instruction carries an immediate
- out_illegal  out  1  unknown opcode

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, in_ready=1, skid empty.
  - out_pc, out_instr and out_imm = 0.
  - out_ext_control=3'b000, out_has_imm=0, out_illegal=0.
- Decode uses opcode=instr[6:0] and f3=instr[14:12]:
  - 0000011 LOAD, 0001111 FENCE, 1100111 JALR -> 000 (I).
  - 0010011 OP-IMM: f3=001 or 101 -> 101 (uimm shamt); otherwise 000.
  - 0100011 STORE -> 001 (S).
  - 1100011 BRANCH -> 010 (B).
  - 0110111 LUI, 0010111 AUIPC -> 011 (U).
  - 1101111 JAL -> 100 (J).
  - 1110011 SYSTEM -> 110 (bypass).
  - 0110011 OP -> has_imm=0, ext_control=000, imm forced to 0.
  - Any other opcode -> illegal=1, has_imm=0, ext_control=111, imm forced to 0; the entry still flows downstream.
- The extender's src input is instr[31:7]. out_imm never carries X.
- Format arithmetic:
  - I = sign-extend instr[31:20].
  - S = sign-extend {instr[31:25], instr[11:7]}.
  - B = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - uimm = zero-extend instr[24:20].
  - bypass = {instr[31:7], 7'b0}.
- Handshake:
  - Transfer on valid && ready, both sides.
  - Latency is 1 cycle, input accept to out_valid.
  - out_valid must not drop, and out_* must stay stable, while out_valid && !out_ready.
- Skid buffer, two entries: output register plus skid register.
  - in_ready = !skid_valid (registered).
  - Accept while the output register is empty or draining: the new entry goes to the output register.
  - Accept while the output register is stalled: the new entry goes to skid, and in_ready=0 next cycle.
  - Output drains with skid full: skid moves to the output register, and in_ready=1 next cycle.
  - Sustained in_valid=out_ready=1 gives 1 entry/cycle with no bubble.
- Flush:
  - On the edge with flush=1, both valids clear and in_ready=1 next cycle.
  - An input presented in the same cycle is discarded, even if in_ready=1.
  - Flush has priority over all transfers.
- Simultaneous accept and drain with skid empty: the output register reloads with the new entry and out_valid stays 1.
- Reset mid-operation drops all entries immediately (asynchronous).
- Data registers load only on enable. Valid bits alone are reset-critical, but data registers also reset to 0 for determinism.

Decomposition:
- Shared package rv_decode_pkg holds:
  - opcode localparams OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_OP, OPC_FENCE;
  - enum ext_ctrl_e covering EXT_I=000, EXT_S=001, EXT_B=010, EXT_U=011, EXT_J=100, EXT_UIMM=101, EXT_BYPASS=110, EXT_NONE=111;
  - a packed struct decode_entry_t {pc, instr, imm, ext_control, has_imm, illegal}.
- The existing extender module is instantiated as-is on the input side, combinational before the register.
- One natural sub-module is skid_buffer, parameterised on the entry type, owning the valid/ready logic.

Test Plan:
- Reset, then feed 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, ext_control=000.
- Stream back-to-back: sw 0xFE112E23, beq 0xFE000EE3, lui 0x123450B7, jal 0x800000EF, slli 0x01F09093.
  - Required imm: 0xFFFFFFFC, 0xFFFFFFFC, 0x12345000, 0xFFF00000, 0x0000001F.
  - Required throughput: one per cycle, no bubbles.
- Hold out_ready=0 while offering 3 instructions:
  - First goes to output, second to skid; in_ready=0 from the following cycle; the third is held upstream.
  - Raise out_ready: the order is preserved and in_ready returns to 1 one cycle after the skid drains.
- Feed add 0x002081B3 -> has_imm=0, out_imm=0. Feed 0x0000007F -> illegal=1, ext_control=111, out_imm=0.
- With both entries full and in_valid=1, assert flush for 1 cycle:
  - Next cycle out_valid=0, in_ready=1.
  - The flushed-cycle input never appears at the output.
- Assert rst_n=0 asynchronously between clock edges while out_valid=1 -> out_valid=0 immediately, before the next clock edge.
